cpu_program_loader: RTL and testbench
=====================================

# cpu_program_loader

Boot-time loader that sits directly upstream of `cpu`. It accepts a 32-bit valid/ready word stream and unpacks it into writes on the CPU's external instruction-memory and data-memory ports (`*_ext`, `*_ext_2`). When the image is complete it asserts the CPU `enable`. It also owns `enable` afterwards: a `halt` request returns the core to idle.

## Interface
Parameters:
- `IMEM_DEPTH`, 512: instruction-memory capacity in 32-bit words.
- `DMEM_DEPTH`, 1024: data-memory capacity in 64-bit words.

Ports:
- `clk`  in  1  clock; one clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  begin a load; honoured only in IDLE or ERR.
- `halt`  in  1  in RUN, drop `cpu_enable` and return to IDLE.
- `s_valid`  in  1  stream word valid.
- `s_ready`  out  1  loader can accept a word.
- `s_data`  in  32  stream word.
- `addr_ext`  out  64  IMEM byte address.
- `wen_ext`  out  1  IMEM write strobe.
- `ren_ext`  out  1  constant 0.
- `wdata_ext`  out  32  IMEM write word.
- `addr_ext_2`  out  64  DMEM byte address.
- `wen_ext_2`  out  1  DMEM write strobe.
- `ren_ext_2`  out  1  constant 0.
- `wdata_ext_2`  out  64  DMEM write word.
- `cpu_enable`  out  1  drives `cpu.enable`.
- `busy`  out  1  high in HDR, IMEM, DMEM_LO, DMEM_HI, DRAIN.
- `error`  out  1  high in ERR.

## Operation
States: IDLE, HDR, IMEM, DMEM_LO, DMEM_HI, DRAIN, RUN, ERR.

- **Reset values:** all outputs are 0, the state is IDLE, and all counters are 0.
- **`s_ready`:** 1 only in HDR, IMEM, DMEM_LO and DMEM_HI. A beat is accepted when `s_valid & s_ready` at a rising edge.
- **IDLE:**
  - `start` → HDR.
- **HDR:** on accept, latch `icnt = s_data[15:0]` and `dcnt = s_data[31:16]`.
  - If `icnt > IMEM_DEPTH` or `dcnt > DMEM_DEPTH` → ERR.
  - Else if `icnt != 0` → IMEM.
  - Else if `dcnt != 0` → DMEM_LO.
  - Else → DRAIN.
- **IMEM:** beat k (k = 0..icnt-1) produces a write with `wdata_ext = s_data` and `addr_ext = 4*k`.
  - After beat icnt-1: → DMEM_LO if `dcnt != 0`, else → DRAIN.
- **DMEM_LO:** on accept, hold `s_data` as the low half → DMEM_HI.
- **DMEM_HI:** on accept, write `wdata_ext_2 = {s_data, low}` with `addr_ext_2 = 8*j` (j = 0..dcnt-1).
  - If j < dcnt-1 → DMEM_LO.
  - Otherwise → DRAIN.
- **DRAIN:** one cycle, no stream acceptance → RUN.
- **RUN:**
  - `cpu_enable = 1`, `s_ready = 0`.
  - `halt` → IDLE, with `cpu_enable` 0 from the next cycle.
  - `start` is ignored.
- **ERR:**
  - `error = 1`, no writes.
  - `start` → HDR, clearing `error`.
- **Precedence:** `rst` overrides everything. A beat accepted on the same edge that reset is sampled produces no write. `start` outside IDLE/ERR is ignored. `halt` outside RUN is ignored.
- **Address arithmetic:** 64-bit byte addresses. Index counters are 16-bit and zero-extended before scaling. Addresses never wrap, because the depth check bounds them.

## Timing
- **Write strobes:** all write outputs are registered. A beat accepted at edge t drives `wen_ext`/`wen_ext_2` high for exactly the cycle after t, with matching address and data. Strobes are never back-to-back on both memories in the same cycle.
- **Address/data between writes:** they hold their last value; `wen` low returns to 0 after one cycle.
- **Throughput:** one beat per cycle when `s_valid` is held. Stream bubbles produce no strobes and no state change.
- **Enable latency:** the final write beat (or the header, if both counts are 0) is accepted at edge t. The last strobe occurs in cycle t+1, DRAIN covers that same cycle, and `cpu_enable` is high from cycle t+2. Enable therefore never overlaps an external write.
- **ERR entry:** `error` rises the cycle after the offending header is accepted.

## Test plan
- **IMEM-only load:** header `0x0000_0002`, then words `0x00500093`, `0x00000013` with continuous valid → `wen_ext` pulses at addr 0 and addr 4 with those data; `cpu_enable` rises 2 cycles after the last accept; `wen_ext_2` never pulses.
- **DMEM packing:** header `0x0001_0000`, then beats `0xDEADBEEF`, `0x01234567` → a single `wen_ext_2` pulse with addr 0 and `wdata_ext_2 = 0x01234567DEADBEEF`; no IMEM strobe.
- **Backpressure:** header `0x0002_0001` with `s_valid` toggled 1,0,0,1,… → exactly 1 IMEM and 2 DMEM strobes (DMEM addrs 0 and 8), each one cycle after its accept, and `s_ready` never high in DRAIN/RUN.
- **Overflow:** header `0x0000_0201` (513 > 512) → `error = 1` the next cycle, `s_ready = 0`, no strobes; then `start` plus header `0x0000_0000` → `error` clears and `cpu_enable` is high 2 cycles after the header accept.
- **Reset mid-load:** assert `rst` after 3 of 8 IMEM beats, on an accept edge → no strobe for that beat, all outputs 0, state IDLE; a fresh full load then succeeds from addr 0.
- **Halt:** in RUN, pulse `halt` → `cpu_enable` 0 next cycle; the following `start` re-enters HDR and `busy = 1`.

Source files
------------

// File: rtl/cpu_program_loader_if.sv
// rtl/cpu_program_loader_if.sv - stream input and external memory write bus for the program loader
interface cpu_program_loader_if;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic [63:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;
    logic [63:0] addr_ext_2;
    logic        wen_ext_2;
    logic        ren_ext_2;
    logic [63:0] wdata_ext_2;

    // Upstream side: drives the word stream, observes the memory writes.
    modport master (
        output s_valid, s_data,
        input  s_ready,
        input  addr_ext, wen_ext, ren_ext, wdata_ext,
        input  addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
    );

    // Loader side: consumes the word stream, produces the memory writes.
    modport slave (
        input  s_valid, s_data,
        output s_ready,
        output addr_ext, wen_ext, ren_ext, wdata_ext,
        output addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
    );
endinterface

// File: rtl/cpu_program_loader.sv
// rtl/cpu_program_loader.sv - unpacks a boot word stream into CPU IMEM/DMEM writes, then enables the core
module cpu_program_loader #(
    parameter int IMEM_DEPTH = 512,
    parameter int DMEM_DEPTH = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    halt,
    cpu_program_loader_if.slave     bus,
    output logic                    cpu_enable,
    output logic                    busy,
    output logic                    error
);
    typedef enum logic [2:0] {
        IDLE, HDR, IMEM, DMEM_LO, DMEM_HI, DRAIN, RUN, ERR
    } state_t;

    localparam logic [31:0] IMEM_LIM = IMEM_DEPTH;
    localparam logic [31:0] DMEM_LIM = DMEM_DEPTH;

    state_t      state_q, state_d;
    logic [15:0] icnt, dcnt, idx;
    logic [31:0] low_half;
    logic        accept;
    logic        hdr_bad;
    logic        last_i, last_d;

    assign accept  = bus.s_valid & bus.s_ready;
    assign hdr_bad = ({16'd0, bus.s_data[15:0]}  > IMEM_LIM) ||
                     ({16'd0, bus.s_data[31:16]} > DMEM_LIM);
    // idx walks both sections; the count is nonzero whenever these are consulted.
    assign last_i  = (idx == icnt - 16'd1);
    assign last_d  = (idx == dcnt - 16'd1);

    assign bus.ren_ext   = 1'b0;
    assign bus.ren_ext_2 = 1'b0;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state selection and state-decoded status outputs.
    always_comb begin
        state_d     = state_q;
        bus.s_ready = 1'b0;
        busy        = 1'b0;
        error       = 1'b0;
        cpu_enable  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = HDR;
            end
            HDR: begin
                bus.s_ready = 1'b1;
                busy        = 1'b1;
                if (accept) begin
                    if (hdr_bad)                     state_d = ERR;
                    else if (bus.s_data[15:0] != 0)  state_d = IMEM;
                    else if (bus.s_data[31:16] != 0) state_d = DMEM_LO;
                    else                             state_d = DRAIN;
                end
            end
            IMEM: begin
                bus.s_ready = 1'b1;
                busy        = 1'b1;
                if (accept && last_i) state_d = (dcnt != 16'd0) ? DMEM_LO : DRAIN;
            end
            DMEM_LO: begin
                bus.s_ready = 1'b1;
                busy        = 1'b1;
                if (accept) state_d = DMEM_HI;
            end
            DMEM_HI: begin
                bus.s_ready = 1'b1;
                busy        = 1'b1;
                if (accept) state_d = last_d ? DRAIN : DMEM_LO;
            end
            DRAIN: begin
                busy    = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                cpu_enable = 1'b1;
                if (halt) state_d = IDLE;
            end
            ERR: begin
                error = 1'b1;
                if (start) state_d = HDR;
            end
            default: state_d = IDLE;
        endcase
    end

    // Header latch, index counting and registered memory write outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            icnt            <= '0;
            dcnt            <= '0;
            idx             <= '0;
            low_half        <= '0;
            bus.wen_ext     <= 1'b0;
            bus.addr_ext    <= '0;
            bus.wdata_ext   <= '0;
            bus.wen_ext_2   <= 1'b0;
            bus.addr_ext_2  <= '0;
            bus.wdata_ext_2 <= '0;
        end else begin
            bus.wen_ext   <= 1'b0;
            bus.wen_ext_2 <= 1'b0;
            if (accept) begin
                case (state_q)
                    HDR: begin
                        icnt <= bus.s_data[15:0];
                        dcnt <= bus.s_data[31:16];
                        idx  <= '0;
                    end
                    IMEM: begin
                        bus.wen_ext   <= 1'b1;
                        bus.addr_ext  <= {46'd0, idx, 2'b00};
                        bus.wdata_ext <= bus.s_data;
                        idx           <= last_i ? 16'd0 : idx + 16'd1;
                    end
                    DMEM_LO: begin
                        low_half <= bus.s_data;
                    end
                    DMEM_HI: begin
                        bus.wen_ext_2   <= 1'b1;
                        bus.addr_ext_2  <= {45'd0, idx, 3'b000};
                        bus.wdata_ext_2 <= {bus.s_data, low_half};
                        idx             <= last_d ? 16'd0 : idx + 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cpu_program_loader.sv
// tb/tb_cpu_program_loader.sv - scoreboard bench for cpu_program_loader
module tb_cpu_program_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic halt = 1'b0;
    logic cpu_enable, busy, error;

    cpu_program_loader_if ifc ();

    cpu_program_loader #(.IMEM_DEPTH(512), .DMEM_DEPTH(1024)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .halt       (halt),
        .bus        (ifc.slave),
        .cpu_enable (cpu_enable),
        .busy       (busy),
        .error      (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mem;
        logic [63:0] addr;
        logic [63:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  total = 0;
    int  bad = 0;
    logic acc_q = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic mem, input logic [63:0] addr, input logic [63:0] data);
        wr_t w;
        w.mem = mem; w.addr = addr; w.data = data;
        exp_q.push_back(w);
    endtask

    // Remember whether a beat was accepted at each edge, so strobes can be tied to it.
    always @(posedge clk) acc_q <= ifc.s_valid & ifc.s_ready & ~rst;

    // Monitor: pop the scoreboard on every write strobe.
    always @(negedge clk) begin
        if (ifc.wen_ext || ifc.wen_ext_2) begin
            chk("strobe_follows_accept", {63'd0, acc_q}, 64'd1);
            chk("single_strobe", {63'd0, ifc.wen_ext & ifc.wen_ext_2}, 64'd0);
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_write: mem=%0d addr=%h got none expected", ifc.wen_ext_2, ifc.wen_ext ? ifc.addr_ext : ifc.addr_ext_2);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                if (ifc.wen_ext) begin
                    chk("wr_mem", 64'd0, {63'd0, w.mem});
                    chk("wr_addr", ifc.addr_ext, w.addr);
                    chk("wr_data", {32'd0, ifc.wdata_ext}, w.data);
                end else begin
                    chk("wr_mem", 64'd1, {63'd0, w.mem});
                    chk("wr_addr", ifc.addr_ext_2, w.addr);
                    chk("wr_data", ifc.wdata_ext_2, w.data);
                end
            end
        end
        if (!rst) begin
            chk("ren_zero", {62'd0, ifc.ren_ext, ifc.ren_ext_2}, 64'd0);
        end
    end

    // Offer one word until accepted; valid stays up for back-to-back words.
    task automatic send(input logic [31:0] d);
        logic r;
        int   n;
        n = 0;
        r = 1'b0;
        while (!r && n < 20) begin
            @(negedge clk);
            ifc.s_valid = 1'b1;
            ifc.s_data  = d;
            r = ifc.s_ready;
            @(posedge clk);
            n++;
        end
        if (!r) begin
            total++; bad++;
            $display("FAIL send_timeout: got ready=0 expected ready=1");
        end
    endtask

    task automatic bubbles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ifc.s_valid = 1'b0;
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        ifc.s_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", {63'd0, busy}, 64'd1);
        chk("start_ready", {63'd0, ifc.s_ready}, 64'd1);
    endtask

    // Called right after the last accepting edge t: DRAIN in t+1, RUN from t+2.
    task automatic check_enable(input string tag);
        @(negedge clk);
        ifc.s_valid = 1'b0;
        chk({tag, "_drain_en"}, {63'd0, cpu_enable}, 64'd0);
        chk({tag, "_drain_rdy"}, {63'd0, ifc.s_ready}, 64'd0);
        chk({tag, "_drain_busy"}, {63'd0, busy}, 64'd1);
        @(negedge clk);
        chk({tag, "_run_en"}, {63'd0, cpu_enable}, 64'd1);
        chk({tag, "_run_rdy"}, {63'd0, ifc.s_ready}, 64'd0);
        chk({tag, "_run_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_halt();
        @(negedge clk);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        chk("halt_en", {63'd0, cpu_enable}, 64'd0);
    endtask

    initial begin
        ifc.s_valid = 1'b0;
        ifc.s_data  = '0;
        repeat (3) @(negedge clk);
        chk("rst_outs", {58'd0, ifc.s_ready, ifc.wen_ext, ifc.wen_ext_2, cpu_enable, busy, error}, 64'd0);
        chk("rst_addr", ifc.addr_ext | ifc.addr_ext_2, 64'd0);
        rst = 1'b0;

        // IMEM-only load
        do_start();
        push(1'b0, 64'd0, 64'h0050_0093);
        push(1'b0, 64'd4, 64'h0000_0013);
        send(32'h0000_0002);
        send(32'h0050_0093);
        send(32'h0000_0013);
        check_enable("imem");
        do_halt();

        // DMEM packing
        do_start();
        push(1'b1, 64'd0, 64'h0123_4567_DEAD_BEEF);
        send(32'h0001_0000);
        send(32'hDEAD_BEEF);
        send(32'h0123_4567);
        check_enable("dmem");
        do_halt();

        // Backpressure: 1 IMEM word, 2 DMEM words with bubbles between beats
        do_start();
        push(1'b0, 64'd0, 64'h0000_00AA);
        push(1'b1, 64'd0, 64'h2222_2222_1111_1111);
        push(1'b1, 64'd8, 64'h4444_4444_3333_3333);
        send(32'h0002_0001); bubbles(2);
        send(32'h0000_00AA); bubbles(2);
        send(32'h1111_1111); bubbles(2);
        send(32'h2222_2222); bubbles(2);
        send(32'h3333_3333); bubbles(2);
        send(32'h4444_4444);
        check_enable("bp");
        do_halt();

        // Overflow header, then recovery with an empty image
        do_start();
        send(32'h0000_0201);
        @(negedge clk);
        ifc.s_valid = 1'b0;
        chk("ovf_error", {63'd0, error}, 64'd1);
        chk("ovf_ready", {63'd0, ifc.s_ready}, 64'd0);
        chk("ovf_busy", {63'd0, busy}, 64'd0);
        repeat (3) @(negedge clk);
        chk("ovf_hold", {63'd0, error}, 64'd1);
        do_start();
        chk("ovf_clear", {63'd0, error}, 64'd0);
        send(32'h0000_0000);
        check_enable("empty");
        do_halt();

        // Reset mid-load on the third beat's accept edge
        do_start();
        push(1'b0, 64'd0, 64'h0000_1000);
        push(1'b0, 64'd4, 64'h0000_1001);
        send(32'h0000_0008);
        send(32'h0000_1000);
        send(32'h0000_1001);
        @(negedge clk);
        ifc.s_valid = 1'b1;
        ifc.s_data  = 32'h0000_1002;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ifc.s_valid = 1'b0;
        chk("mid_rst_outs", {58'd0, ifc.s_ready, ifc.wen_ext, ifc.wen_ext_2, cpu_enable, busy, error}, 64'd0);
        chk("mid_rst_addr", ifc.addr_ext, 64'd0);
        chk("mid_rst_sb", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        chk("mid_rst_idle", {63'd0, busy}, 64'd0);
        do_start();
        send(32'h0000_0008);
        for (int k = 0; k < 8; k++) begin
            push(1'b0, 64'(4 * k), 64'(32'h0000_2000 + k));
            send(32'h0000_2000 + 32'(k));
        end
        check_enable("reload");

        // start in RUN is ignored; halt then start re-enters HDR
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("run_start_ign", {62'd0, cpu_enable, busy}, 64'd2);
        do_halt();
        do_start();

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
